// File: rtl/scoreboard_game_ctrl.sv
// Scoreboard game controller: button conditioning, countdown game clock and team scores.
// Optional macro GAME_OVER_LOCK_EN: ignore score events while the game clock is expired.
module scoreboard_game_ctrl #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned GAME_MINUTES    = 20,
  parameter int unsigned MAX_SCORE       = 99
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_reset_points,
  input  logic       i_reset_score,
  input  logic       i_one_point_t1,
  input  logic       i_one_point_t2,
  input  logic       i_pause,
  output logic [7:0] o_minutes,
  output logic [7:0] o_seconds,
  output logic [7:0] o_t1,
  output logic [7:0] o_t2,
  output logic       o_running,
  output logic       o_expired
);

  localparam int unsigned NumBtn = 5;
  localparam int unsigned BtnRp  = 0;
  localparam int unsigned BtnRs  = 1;
  localparam int unsigned BtnT1  = 2;
  localparam int unsigned BtnT2  = 3;
  localparam int unsigned BtnP   = 4;

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PsW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [DbW-1:0] DbLast   = DbW'(DEBOUNCE_CYCLES);
  localparam logic [PsW-1:0] PsLast   = PsW'(CLK_HZ - 1);
  localparam logic [7:0]     LoadMin  = 8'(GAME_MINUTES);
  localparam logic [7:0]     ScoreMax = 8'(MAX_SCORE);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  logic [NumBtn-1:0] w_raw;
  logic [NumBtn-1:0] r_sync1, r_sync2, r_acc, r_evt;
  logic [DbW-1:0]    r_cnt [NumBtn];

  state_e         r_state, w_state_next;
  logic [PsW-1:0] r_presc, w_presc_next;
  logic [7:0]     r_min, w_min_next;
  logic [7:0]     r_sec, w_sec_next;
  logic [7:0]     r_t1, w_t1_next;
  logic [7:0]     r_t2, w_t2_next;
  logic           w_tick;
  logic           w_score_ok;

  assign w_raw = {i_pause, i_one_point_t2, i_one_point_t1, i_reset_score, i_reset_points};

  // Accepted level flips after DEBOUNCE_CYCLES+1 cycles of disagreement; a press
  // emits a registered one-cycle event on the same edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_acc   <= '0;
      r_evt   <= '0;
      for (int i = 0; i < NumBtn; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NumBtn; i++) begin
        r_evt[i] <= 1'b0;
        if (r_sync2[i] == r_acc[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DbLast) begin
          r_cnt[i] <= '0;
          r_acc[i] <= r_sync2[i];
          r_evt[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_tick = (r_state == StRun) && (r_presc == PsLast);

  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_min_next   = r_min;
    w_sec_next   = r_sec;
    unique case (r_state)
      StIdle: begin
        if (r_evt[BtnP]) w_state_next = StRun;
      end
      StRun: begin
        w_presc_next = w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          if (r_sec == 8'd0) begin
            w_sec_next = 8'd59;
            w_min_next = r_min - 8'd1;
          end else begin
            w_sec_next = r_sec - 8'd1;
          end
        end
        // Reaching 00:00 takes priority over a same-cycle pause.
        if (w_tick && r_min == 8'd0 && r_sec == 8'd1) begin
          w_state_next = StExpired;
        end else if (r_evt[BtnP]) begin
          w_state_next = StPaused;
        end
      end
      StPaused: begin
        if (r_evt[BtnP]) w_state_next = StRun;
      end
      StExpired: begin
        w_state_next = StExpired;
      end
      default: w_state_next = StIdle;
    endcase
    if (r_evt[BtnRs]) begin
      w_state_next = StIdle;
      w_presc_next = '0;
      w_min_next   = LoadMin;
      w_sec_next   = 8'd0;
    end
  end

`ifdef GAME_OVER_LOCK_EN
  assign w_score_ok = (r_state != StExpired);
`else
  assign w_score_ok = 1'b1;
`endif

  always_comb begin
    w_t1_next = r_t1;
    w_t2_next = r_t2;
    if (r_evt[BtnRp]) begin
      w_t1_next = 8'd0;
      w_t2_next = 8'd0;
    end else if (w_score_ok) begin
      if (r_evt[BtnT1] && r_t1 < ScoreMax) w_t1_next = r_t1 + 8'd1;
      if (r_evt[BtnT2] && r_t2 < ScoreMax) w_t2_next = r_t2 + 8'd1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_presc <= '0;
      r_min   <= LoadMin;
      r_sec   <= 8'd0;
      r_t1    <= 8'd0;
      r_t2    <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
      r_min   <= w_min_next;
      r_sec   <= w_sec_next;
      r_t1    <= w_t1_next;
      r_t2    <= w_t2_next;
    end
  end

  assign o_minutes = r_min;
  assign o_seconds = r_sec;
  assign o_t1      = r_t1;
  assign o_t2      = r_t2;
  assign o_running = (r_state == StRun);
  assign o_expired = (r_state == StExpired);

endmodule

// File: tb/tb_scoreboard_game_ctrl.sv
// Directed self-checking bench for scoreboard_game_ctrl (CLK_HZ=10, DEBOUNCE_CYCLES=4, 1 minute).
module tb_scoreboard_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;  // {pause, t2, t1, reset_score, reset_points}
  logic [7:0] minutes, seconds, t1, t2;
  logic       running, expired;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] BRp = 5'b00001;
  localparam logic [4:0] BRs = 5'b00010;
  localparam logic [4:0] BT1 = 5'b00100;
  localparam logic [4:0] BT2 = 5'b01000;
  localparam logic [4:0] BP  = 5'b10000;

  scoreboard_game_ctrl #(
    .CLK_HZ         (10),
    .DEBOUNCE_CYCLES(4),
    .GAME_MINUTES   (1),
    .MAX_SCORE      (99)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_reset_points(btn[0]),
    .i_reset_score (btn[1]),
    .i_one_point_t1(btn[2]),
    .i_one_point_t2(btn[3]),
    .i_pause       (btn[4]),
    .o_minutes     (minutes),
    .o_seconds     (seconds),
    .o_t1          (t1),
    .o_t2          (t2),
    .o_running     (running),
    .o_expired     (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Event takes effect on the 8th edge; then release and let the release debounce settle.
  task automatic press(input logic [4:0] m);
    btn = m;
    cyc(8);
    btn = '0;
    cyc(8);
  endtask

  initial begin
    logic [7:0] t2_exp;
    cyc(2);
    rst = 1'b0;
    check("rst_min", minutes, 1);
    check("rst_sec", seconds, 0);
    check("rst_t1", t1, 0);
    check("rst_t2", t2, 0);
    check("rst_run", running, 0);
    check("rst_exp", expired, 0);

    // Debounce
    btn = BT1; cyc(2); btn = '0; cyc(10);
    check("glitch_t1", t1, 0);
    btn = BT1; cyc(7);
    check("db_early", t1, 0);
    cyc(1);
    check("db_on_time", t1, 1);
    cyc(22); btn = '0; cyc(10);
    check("db_release", t1, 1);

    // Countdown with pause/resume
    btn = BP; cyc(8);
    check("start_run", running, 1);
    btn = '0; cyc(9);
    check("pre_tick_sec", seconds, 0);
    check("pre_tick_min", minutes, 1);
    cyc(1);
    check("tick1_min", minutes, 0);
    check("tick1_sec", seconds, 59);
    cyc(8); btn = BP; cyc(8);
    check("paused_run", running, 0);
    check("paused_sec", seconds, 58);
    btn = '0; cyc(50);
    check("hold_sec", seconds, 58);
    check("hold_run", running, 0);
    btn = BP; cyc(8);
    check("resume_run", running, 1);
    btn = '0; cyc(3);
    check("resume_pre", seconds, 58);
    cyc(1);
    check("resume_tick", seconds, 57);
    cyc(569);
    check("near_end_sec", seconds, 1);
    check("near_end_exp", expired, 0);
    cyc(1);
    check("end_min", minutes, 0);
    check("end_sec", seconds, 0);
    check("end_exp", expired, 1);
    check("end_run", running, 0);
    press(BP);
    check("exp_pause_exp", expired, 1);
    check("exp_pause_run", running, 0);
    press(BT2);
`ifdef GAME_OVER_LOCK_EN
    t2_exp = 8'd0;
`else
    t2_exp = 8'd1;
`endif
    check("exp_t2", t2, t2_exp);
    press(BRs);
    check("reload_exp", expired, 0);
    check("reload_min", minutes, 1);
    check("reload_sec", seconds, 0);

    // Reload during RUN at 00:37
    btn = BP; cyc(8);
    check("run2", running, 1);
    btn = '0; cyc(227);
    btn = BRs; cyc(7);
    check("at37_sec", seconds, 37);
    check("at37_min", minutes, 0);
    cyc(1);
    check("rs_min", minutes, 1);
    check("rs_sec", seconds, 0);
    check("rs_run", running, 0);
    btn = '0; cyc(10);
    btn = BP; cyc(8);
    check("run3", running, 1);
    btn = '0; cyc(9);
    check("presc0_pre", seconds, 0);
    cyc(1);
    check("presc0_tick", seconds, 59);
    press(BRs);
    check("idle_again", running, 0);

    // Scores
    press(BRp);
    check("rp_t1", t1, 0);
    check("rp_t2", t2, 0);
    for (int i = 0; i < 99; i++) press(BT1);
    check("sat_99", t1, 99);
    press(BT1);
    check("sat_hold", t1, 99);
    press(BRp);
    check("clr_t1", t1, 0);
    press(BT1 | BT2);
    check("both_t1", t1, 1);
    check("both_t2", t2, 1);
    press(BT2);
    check("t2_two", t2, 2);
    press(BRp | BT2);
    check("rp_wins_t2", t2, 0);
    check("rp_wins_t1", t1, 0);

    // Async reset mid-debounce
    press(BT1);
    check("pre_ar_t1", t1, 1);
    press(BP);
    btn = BT1; cyc(3);
    check("pre_ar_min", minutes, 0);
    #2 rst = 1'b1;
    #1;
    check("ar_t1", t1, 0);
    check("ar_min", minutes, 1);
    check("ar_sec", seconds, 0);
    check("ar_run", running, 0);
    check("ar_exp", expired, 0);
    btn = '0; cyc(2);
    rst = 1'b0; cyc(20);
    check("ar_no_evt", t1, 0);
    check("ar_idle", running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scoreboard_game_ctrl.md
# scoreboard_game_ctrl

Game controller for the Basys 3 scoreboard. It debounces the five front-panel buttons and runs the countdown game clock from a 100 MHz source. It keeps both team scores and drives the minutes, seconds, team-1 and team-2 values that the 8-digit seven-segment multiplexer shows. It sits between the raw board inputs and the display driver.

## Interface
Parameters:
- CLK_HZ, 100_000_000, clock cycles per game-clock second.
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronized button level must stay stable before it is accepted. Minimum 2.
- GAME_MINUTES, 20, game-clock load value in minutes. Range 1..99.
- MAX_SCORE, 99, score saturation value. Maximum 99.

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high; clears all state
- reset_points  in  1  raw button; clears both scores
- reset_score  in  1  raw button; reloads the game clock
- one_point_t1  in  1  raw button; team 1 scores +1
- one_point_t2  in  1  raw button; team 2 scores +1
- pause  in  1  raw button; start/pause/resume the game clock
- minutes  out  8  game-clock minutes, binary 0..99
- seconds  out  8  game-clock seconds, binary 0..59
- t1  out  8  team 1 score, binary
- t2  out  8  team 2 score, binary
- running  out  1  high in state RUN
- expired  out  1  high in state EXPIRED

## Operation
- Button conditioning. Each raw button is handled identically and independently:
  - 2-flop synchronizer.
  - Debounce counter: counts while the synchronized level differs from the accepted level; clears when they match. When the count reaches DEBOUNCE_CYCLES, the accepted level takes the synchronized level.
  - A rising edge of the accepted level gives a 1-cycle event pulse.
  - Releases produce no event. A held button produces exactly one event.
- State machine, with states IDLE, RUN, PAUSED and EXPIRED:
  - IDLE: game clock loaded, not counting. A pause event moves to RUN.
  - RUN: the prescaler counts 0..CLK_HZ-1. At its terminal count a tick occurs.
    - On a tick: if seconds = 0, then seconds ← 59 and minutes ← minutes − 1; otherwise seconds ← seconds − 1.
    - If the new value is 00:00, move to EXPIRED in the same edge.
    - A pause event moves to PAUSED.
  - PAUSED: the prescaler holds its value, so the fractional second is kept. A pause event moves to RUN.
  - EXPIRED: the clock stays at 00:00 and pause events are ignored.
  - In any state, a reset_score event loads GAME_MINUTES:00, clears the prescaler and moves to IDLE.
- Scores:
  - A one_point_tN event increments tN.
  - The score saturates at MAX_SCORE; an increment at MAX_SCORE is dropped.
  - Score events are accepted in every state, except as given under Configuration.
  - A reset_points event clears both t1 and t2 to 0.
- Simultaneous events in one cycle:
  - t1 and t2 events: both scores increment.
  - reset_points with a score event: clear wins.
  - reset_score with a tick or a pause event: reload wins and the state is IDLE.
  - A tick and a pause event: the tick is applied, then the state becomes PAUSED.

## Timing
- Reset values:
  - minutes = GAME_MINUTES, seconds = 0, t1 = t2 = 0.
  - running = 0, expired = 0, state IDLE.
  - Prescaler, debounce counters, synchronizers and accepted levels are all 0.
- Event latency: a raw rising edge that is held steady produces its event pulse on clock edge 2 + DEBOUNCE_CYCLES + 1 after the first edge that samples it high.
- Output latency: outputs are registered and update on the edge after the event pulse. running and expired track the state register directly.
- Tick period: the first tick comes CLK_HZ cycles after entering RUN from IDLE. Later ticks come every CLK_HZ RUN cycles; PAUSED cycles are not counted.
- A full game from 20:00 reaches EXPIRED after exactly 1200 × CLK_HZ RUN cycles.
- Asserting reset mid-operation returns everything to the reset values asynchronously. Any in-flight debounce is discarded.

## Configuration
- GAME_OVER_LOCK_EN defined: one_point_t1 and one_point_t2 events are ignored while in EXPIRED. reset_points still clears the scores.
- GAME_OVER_LOCK_EN undefined: score events are accepted in all states.

## Test plan
Benches use CLK_HZ = 10, DEBOUNCE_CYCLES = 4, GAME_MINUTES = 1 unless a scenario says otherwise.
- Debounce: a raw one_point_t1 with a 2-cycle glitch gives no change. Holding it high for 30 cycles gives t1 = 1 exactly 7 edges after sampling, and releasing it gives no further change.
- Countdown:
  - A pause event in IDLE sets running = 1.
  - After 10 cycles, the display reads 00:59.
  - After 600 RUN cycles total, it reads 00:00 with expired = 1 and running = 0.
  - A further pause event leaves it in EXPIRED.
- Pause/resume: pause at prescaler count 6, hold 50 cycles (clock unchanged), resume. The next tick comes 4 cycles later.
- Saturation and simultaneous events:
  - Drive t1 to 99; one more event leaves t1 = 99.
  - Same-cycle t1 and t2 events give t1 and t2 each +1.
  - reset_points in the same cycle as a t2 event gives t2 = 0.
- Reload: reset_score during RUN at 00:37 gives 01:00, state IDLE, prescaler 0. Async reset mid-debounce clears the outputs to their reset values and produces no spurious event.
- Config: with GAME_OVER_LOCK_EN, a t2 event in EXPIRED leaves t2 unchanged. Without it, t2 increments.
